// File: rtl/camera_pixel_assembler.sv
// Camera pixel reconstruction: synchronises the parallel camera pins into clk_in,
// assembles 1-4 bytes per pixel and reports coordinates, line/frame pulses and errors.
module camera_pixel_assembler #(
    parameter int unsigned HCOUNT_WIDTH    = 11,
    parameter int unsigned VCOUNT_WIDTH    = 10,
    parameter int unsigned BYTES_PER_PIXEL = 2,
    parameter int unsigned HS_ACTIVE_HIGH  = 1,
    parameter int unsigned VS_ACTIVE_HIGH  = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         camera_pclk_in,
    input  logic                         camera_hs_in,
    input  logic                         camera_vs_in,
    input  logic [7:0]                   camera_data_in,
    input  logic                         msb_first_in,
    input  logic                         err_clr_in,
    output logic                         pixel_valid_out,
    output logic [HCOUNT_WIDTH-1:0]      pixel_hcount_out,
    output logic [VCOUNT_WIDTH-1:0]      pixel_vcount_out,
    output logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out,
    output logic                         line_done_out,
    output logic [HCOUNT_WIDTH-1:0]      line_width_out,
    output logic                         frame_done_out,
    output logic [15:0]                  frame_count_out,
    output logic [1:0]                   err_out
);

    localparam int unsigned PIX_W = 8 * BYTES_PER_PIXEL;
    localparam int unsigned IDX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);
    localparam logic HS_INV = (HS_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
    localparam logic VS_INV = (VS_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {SYNC, FRAME, LINE} state_t;

    logic       pclk_s1_q, pclk_s2_q, pclk_d_q;
    logic       hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [7:0] data_s1_q, data_s2_q;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic                    msb_q, msb_d;
    logic                    in_frame_q, in_frame_d;
    logic [PIX_W-1:0]        asm_q, asm_d;
    logic [HCOUNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [VCOUNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic                    pixel_valid_q, pixel_valid_d;
    logic [HCOUNT_WIDTH-1:0] hcount_q, hcount_d;
    logic [VCOUNT_WIDTH-1:0] vcount_q, vcount_d;
    logic [PIX_W-1:0]        pixel_data_q, pixel_data_d;
    logic                    line_done_q, line_done_d;
    logic [HCOUNT_WIDTH-1:0] width_q, width_d;
    logic                    frame_done_q, frame_done_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [1:0]              err_q, err_d;

    logic             sample, hs_act, vs_act;
    logic             do_byte, line_end, line_inc, frame_end, cur_msb;
    logic [IDX_W-1:0] cur_idx, lane;
    logic [PIX_W-1:0] word;

    // Equal-depth synchronisers keep pclk, syncs and data aligned
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pclk_s1_q <= 1'b0;
            pclk_s2_q <= 1'b0;
            pclk_d_q  <= 1'b0;
            hs_s1_q   <= 1'b0;
            hs_s2_q   <= 1'b0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            data_s1_q <= 8'h00;
            data_s2_q <= 8'h00;
        end else begin
            pclk_s1_q <= camera_pclk_in;
            pclk_s2_q <= pclk_s1_q;
            pclk_d_q  <= pclk_s2_q;
            hs_s1_q   <= camera_hs_in;
            hs_s2_q   <= hs_s1_q;
            vs_s1_q   <= camera_vs_in;
            vs_s2_q   <= vs_s1_q;
            data_s1_q <= camera_data_in;
            data_s2_q <= data_s1_q;
        end
    end

    assign sample = pclk_s2_q & ~pclk_d_q;
    assign hs_act = hs_s2_q ^ HS_INV;
    assign vs_act = vs_s2_q ^ VS_INV;

    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        msb_d         = msb_q;
        in_frame_d    = in_frame_q;
        asm_d         = asm_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        pixel_valid_d = 1'b0;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        pixel_data_d  = pixel_data_q;
        line_done_d   = 1'b0;
        width_d       = width_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_d         = err_clr_in ? 2'b00 : err_q;
        do_byte       = 1'b0;
        line_end      = 1'b0;
        line_inc      = 1'b0;
        frame_end     = 1'b0;
        cur_idx       = byte_idx_q;
        cur_msb       = msb_q;
        lane          = '0;
        word          = asm_q;

        if (sample) begin
            case (state_q)
                SYNC: begin
                    if (!vs_act) state_d = FRAME;
                    in_frame_d = 1'b0;
                end
                FRAME: begin
                    // Frame end only after the frame was actually seen active
                    if (!vs_act) begin
                        frame_end = in_frame_q;
                    end else begin
                        in_frame_d = 1'b1;
                        if (hs_act) begin
                            state_d = LINE;
                            do_byte = 1'b1;
                            cur_idx = '0;
                        end
                    end
                end
                LINE: begin
                    if (!vs_act) begin
                        line_end  = 1'b1;
                        frame_end = 1'b1;
                    end else if (!hs_act) begin
                        line_end = 1'b1;
                        line_inc = 1'b1;
                        state_d  = FRAME;
                    end else begin
                        do_byte = 1'b1;
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        if (do_byte) begin
            if (cur_idx == '0) cur_msb = msb_first_in;
            lane = cur_msb ? (LAST_IDX - cur_idx) : cur_idx;
            word[{lane, 3'b000} +: 8] = data_s2_q;
            asm_d = word;
            msb_d = cur_msb;
            if (cur_idx == LAST_IDX) begin
                pixel_valid_d = 1'b1;
                pixel_data_d  = word;
                hcount_d      = pix_cnt_q;
                vcount_d      = line_cnt_q;
                byte_idx_d    = '0;
                if (&pix_cnt_q) err_d[1] = 1'b1;
                else            pix_cnt_d = pix_cnt_q + HCOUNT_WIDTH'(1);
            end else begin
                byte_idx_d = cur_idx + IDX_W'(1);
            end
        end

        if (line_end) begin
            line_done_d = 1'b1;
            width_d     = pix_cnt_q;
            if (byte_idx_q != '0) err_d[0] = 1'b1;
            byte_idx_d  = '0;
            pix_cnt_d   = '0;
            state_d     = FRAME;
            if (line_inc && !(&line_cnt_q)) line_cnt_d = line_cnt_q + VCOUNT_WIDTH'(1);
        end

        if (frame_end) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            line_cnt_d   = '0;
            pix_cnt_d    = '0;
            in_frame_d   = 1'b0;
            state_d      = FRAME;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= SYNC;
            byte_idx_q    <= '0;
            msb_q         <= 1'b0;
            in_frame_q    <= 1'b0;
            asm_q         <= '0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            pixel_valid_q <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            pixel_data_q  <= '0;
            line_done_q   <= 1'b0;
            width_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= 16'd0;
            err_q         <= 2'b00;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            msb_q         <= msb_d;
            in_frame_q    <= in_frame_d;
            asm_q         <= asm_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pixel_valid_q <= pixel_valid_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pixel_data_q  <= pixel_data_d;
            line_done_q   <= line_done_d;
            width_q       <= width_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            err_q         <= err_d;
        end
    end

    assign pixel_valid_out  = pixel_valid_q;
    assign pixel_hcount_out = hcount_q;
    assign pixel_vcount_out = vcount_q;
    assign pixel_data_out   = pixel_data_q;
    assign line_done_out    = line_done_q;
    assign line_width_out   = width_q;
    assign frame_done_out   = frame_done_q;
    assign frame_count_out  = frame_cnt_q;
    assign err_out          = err_q;

endmodule

// File: doc/camera_pixel_assembler.md
# camera_pixel_assembler

Parametrised successor to the camera pixel reconstruction stage. It sits between the parallel camera pins and the frame buffer / downscaler. It synchronises PCLK, HSYNC, VSYNC and data into the system clock, then assembles 1–4 camera bytes into one pixel word with runtime-selectable byte order. It emits pixel coordinates, line/frame boundary pulses, measured line width, a frame counter and sticky error flags.

## Interface

Parameters:
- HCOUNT_WIDTH, 11: width of pixel (column) counter and line_width_out.
- VCOUNT_WIDTH, 10: width of line (row) counter.
- BYTES_PER_PIXEL, 2: camera bytes per pixel; legal range 1–4.
- HS_ACTIVE_HIGH, 1: 1 means HSYNC high marks active line; 0 inverts it.
- VS_ACTIVE_HIGH, 1: 1 means VSYNC high marks active frame; 0 inverts it.

Ports:
- clk_in, input, 1: system clock; the only clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- camera_pclk_in, input, 1: camera pixel clock, asynchronous.
- camera_hs_in, input, 1: camera HSYNC, asynchronous.
- camera_vs_in, input, 1: camera VSYNC, asynchronous.
- camera_data_in, input, 8: camera byte, asynchronous.
- msb_first_in, input, 1: 1 means the first byte of a pixel lands in the most-significant byte; 0 means it lands in the least-significant byte. Sampled at each pixel's first byte.
- err_clr_in, input, 1: single-cycle pulse that clears err_out.
- pixel_valid_out, output, 1: one-cycle strobe; pixel_data_out and the coordinates are valid.
- pixel_hcount_out, output, HCOUNT_WIDTH: column of the emitted pixel; first pixel of a line is 0.
- pixel_vcount_out, output, VCOUNT_WIDTH: row of the emitted pixel; first line of a frame is 0.
- pixel_data_out, output, 8*BYTES_PER_PIXEL: assembled pixel.
- line_done_out, output, 1: one-cycle pulse at the end of an active line.
- line_width_out, output, HCOUNT_WIDTH: number of complete pixels in the last finished line. Held until the next line_done_out.
- frame_done_out, output, 1: one-cycle pulse at the end of an active frame.
- frame_count_out, output, 16: frames completed; wraps modulo 2^16.
- err_out, output, 2: sticky flags. Bit 0: partial pixel discarded at line end. Bit 1: pixel counter saturated.

## Operation

- Synchroniser: two-flop synchronisers on pclk, hs, vs and all data bits. All four pass through equal depth, so they stay aligned.
- Edge detect: a third pclk flop drives sample = sync_pclk & ~pclk_d. Every FSM action below occurs only on a sample cycle.
- Polarity normalisation: hs_act and vs_act are the synchronised syncs XORed with the inverse of the matching *_ACTIVE_HIGH parameter.
- FSM states:
  - SYNC: the reset state. Move to FRAME on the first sample where vs_act=0. This ignores any partially observed frame after reset.
  - FRAME: inside a frame, between lines. On hs_act=1 and vs_act=1, go to LINE and process that byte as byte 0.
  - LINE: assembling pixels.
- Byte assembly (in LINE):
  - byte_idx runs 0..BYTES_PER_PIXEL-1 and is cleared on entry to LINE.
  - Each sample writes the byte into slot byte_idx (msb_first_in=1) or slot BYTES_PER_PIXEL-1-byte_idx (msb_first_in=0). Slot 0 is the most-significant byte.
  - When byte_idx reaches BYTES_PER_PIXEL-1, the block registers pixel_data_out, pixel_hcount_out=pix_cnt and pixel_vcount_out=line_cnt, and pulses pixel_valid_out.
  - pix_cnt then increments and saturates at all-ones. An increment attempted at all-ones sets err_out[1].
- Line end: LINE sample with hs_act=0 and vs_act=1.
  - Pulse line_done_out.
  - line_width_out = pix_cnt.
  - If byte_idx≠0, set err_out[0] and discard the partial bytes.
  - pix_cnt=0; line_cnt increments, saturating at all-ones.
  - Go to FRAME.
- Frame end: FRAME or LINE sample with vs_act=0.
  - If in LINE, perform the full line-end action in the same cycle: line_done_out, line_width_out and err_out[0] rules all apply, but line_cnt is not incremented.
  - Pulse frame_done_out and increment frame_count_out.
  - line_cnt=0 and pix_cnt=0.
  - Stay in FRAME, waiting for vs_act=1 (hs_act is ignored while vs_act=0).
- Errors: err_clr_in clears both bits. If a set and a clear land in the same cycle, the set wins.

## Timing

- Reset (async assert, synchronous-release flops): all outputs 0, FSM in SYNC, all counters and synchroniser flops 0.
- Latency: a camera pclk rising edge with stable data/syncs produces pixel_valid_out (or line_done_out / frame_done_out) exactly 3 clk_in cycles after the edge is first registered. That is 2 synchroniser cycles plus 1 output register cycle.
- Strobes: pixel_valid_out, line_done_out and frame_done_out are high for exactly 1 cycle. All are 0 on non-sample cycles.
- Data and coordinate outputs hold their values between strobes.
- Input rate: camera_pclk_in high and low phases must each last ≥2 clk_in periods. Data and syncs must be stable ≥3 clk_in cycles around the pclk rise.
- Reset mid-line: outputs return to 0 immediately and the FSM goes to SYNC. Capture resumes only after a vs_act=0 sample.

## Test plan

- BYTES_PER_PIXEL=2, msb_first_in=1: after a SYNC exit, VS up, HS up, bytes 0x12,0x34,0x56,0x78 → pixel 0x1234 at (h=0,v=0), then pixel 0x5678 at h=1. Each pixel_valid_out is 3 cycles after its second-byte pclk edge.
- Same stimulus with msb_first_in=0 → pixel 0x3412, then pixel 0x7856.
- BYTES_PER_PIXEL=3, one line of 9 bytes, then HS drop → 3 pixels, line_done_out, line_width_out=3. A second line reports v=1 and h restarts at 0.
- BYTES_PER_PIXEL=2, 5-byte line → 2 pixels, line_width_out=2, err_out=2'b01. An err_clr_in pulse then gives err_out=0.
- VS drop while HS is still active, after 2 full lines → line_done_out and frame_done_out in the same cycle, frame_count_out=1. The next frame's first pixel reports v=0.
- Reset asserted while VS is already active mid-frame, then released → no pixel_valid_out until VS goes low and high again. Also, HCOUNT_WIDTH=3 with a 9-pixel line → h saturates at 7 and err_out[1]=1.
